// File: rtl/alu_issue_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_issue_ctrl_if : issue-controller to combinational ALU bus       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface alu_issue_ctrl_if #(
    parameter int DATA_W = 16
) ();
    logic [1:0]        alu_func;
    logic [DATA_W-1:0] alu_src1;
    logic [DATA_W-1:0] alu_src2;
    logic [DATA_W-1:0] alu_result;

    modport master (
        output alu_func,
        output alu_src1,
        output alu_src2,
        input  alu_result
    );

    modport slave (
        input  alu_func,
        input  alu_src1,
        input  alu_src2,
        output alu_result
    );
endinterface
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_issue_ctrl : 4-cycle decode/execute/writeback issue controller  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module alu_issue_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    input  wire logic                    instr_valid_i,
    input  wire logic [4+3*ADDR_W-1:0]   instr_i,
    output logic                         instr_ready_o,
    alu_issue_ctrl_if.master             alu,
    output logic                         done_o,
    output logic                         illegal_o,
    output logic                         wb_en_o,
    output logic [ADDR_W-1:0]            wb_addr_o,
    output logic [DATA_W-1:0]            wb_data_o,
    input  wire logic [ADDR_W-1:0]       dbg_addr_i,
    output logic [DATA_W-1:0]            dbg_data_o
);
    localparam int NREG = 1 << ADDR_W;
    localparam int IW   = 4 + 3*ADDR_W;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_DECODE    = 2'd1;
    localparam logic [1:0] S_EXECUTE   = 2'd2;
    localparam logic [1:0] S_WRITEBACK = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [IW-1:0]     instr_q;
    logic              illegal_flag_q;
    logic [1:0]        alu_func_q;
    logic [DATA_W-1:0] alu_src1_q, alu_src2_q;
    logic              done_q, illegal_q, wb_en_q;
    logic [ADDR_W-1:0] wb_addr_q;
    logic [DATA_W-1:0] wb_data_q;
    logic [DATA_W-1:0] regs_q [NREG];

    logic [3:0]        opcode;
    logic [ADDR_W-1:0] rd, rs1, rs2;
    logic [DATA_W-1:0] rs1_val, rs2_val;

    assign opcode  = instr_q[IW-1 -: 4];
    assign rd      = instr_q[3*ADDR_W-1 -: ADDR_W];
    assign rs1     = instr_q[2*ADDR_W-1 -: ADDR_W];
    assign rs2     = instr_q[ADDR_W-1:0];
    // r0 is hardwired to zero on every read path.
    assign rs1_val = (rs1 == '0) ? '0 : regs_q[rs1];
    assign rs2_val = (rs2 == '0) ? '0 : regs_q[rs2];

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (instr_valid_i) state_d = S_DECODE;
            S_DECODE:    state_d = S_EXECUTE;
            S_EXECUTE:   state_d = S_WRITEBACK;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            instr_q        <= '0;
            illegal_flag_q <= 1'b0;
            alu_func_q     <= 2'b00;
            alu_src1_q     <= '0;
            alu_src2_q     <= '0;
            done_q         <= 1'b0;
            illegal_q      <= 1'b0;
            wb_en_q        <= 1'b0;
            wb_addr_q      <= '0;
            wb_data_q      <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            wb_en_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (instr_valid_i) begin
                        instr_q        <= instr_i;
                        illegal_flag_q <= 1'b0;
                    end
                end
                S_DECODE: begin
                    if (opcode[3:2] == 2'b00) begin
                        alu_func_q <= opcode[1:0];
                        alu_src1_q <= rs1_val;
                        alu_src2_q <= rs2_val;
                    end else begin
                        illegal_flag_q <= 1'b1;
                    end
                end
                S_EXECUTE: begin
                    // Pulses are set here so they are high for exactly the WRITEBACK cycle.
                    done_q    <= 1'b1;
                    illegal_q <= illegal_flag_q;
                    if (!illegal_flag_q && rd != '0) begin
                        wb_en_q   <= 1'b1;
                        wb_addr_q <= rd;
                        wb_data_q <= alu.alu_result;
                    end
                end
                default: begin
                    if (wb_en_q) regs_q[wb_addr_q] <= wb_data_q;
                end
            endcase
        end
    end

    assign instr_ready_o = (state_q == S_IDLE);
    assign alu.alu_func  = alu_func_q;
    assign alu.alu_src1  = alu_src1_q;
    assign alu.alu_src2  = alu_src2_q;
    assign done_o        = done_q;
    assign illegal_o     = illegal_q;
    assign wb_en_o       = wb_en_q;
    assign wb_addr_o     = wb_addr_q;
    assign wb_data_o     = wb_data_q;
    assign dbg_data_o    = (dbg_addr_i == '0) ? '0 : regs_q[dbg_addr_i];
endmodule
`default_nettype wire

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Multi-cycle issue controller that drives the datapath ALU (2-bit func: 00 ADD, 01 SUB, 10 MUL, 11 SLT; 16-bit operands; combinational 16-bit result). It accepts 16-bit register-register instructions over a valid/ready handshake and decodes them. It reads operands from an internal 16x16 register file, presents them to the ALU, captures the result and writes it back. It is the initiator side of the ALU interface, sitting between instruction fetch and the ALU.

Parameters:
DATA_W, 16, operand/result/register width
ADDR_W, 4, register index width (2**ADDR_W registers); instruction width = 4 + 3*ADDR_W

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  instruction present
instr  in  16  [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2
instr_ready  out  1  controller can accept
alu_func  out  2  ALU function select
alu_src1  out  DATA_W  ALU operand A
alu_src2  out  DATA_W  ALU operand B
alu_result  in  DATA_W  ALU result (combinational from alu_* outputs)
done  out  1  one-cycle pulse, instruction retired
illegal  out  1  one-cycle pulse, illegal opcode retired
wb_en  out  1  register write strobe (same cycle as write)
wb_addr  out  ADDR_W  register written
wb_data  out  DATA_W  value written
dbg_addr  in  ADDR_W  debug read index
dbg_data  out  DATA_W  combinational register read, r0 reads 0

Behaviour:
- Reset (async, rst_n=0): FSM to IDLE; all registers r0..r15 = 0; alu_func=00, alu_src1=alu_src2=0; done=illegal=wb_en=0; wb_addr=0, wb_data=0; latched instruction cleared. Reset mid-instruction aborts it with no writeback and no done.
- States: IDLE, DECODE, EXECUTE, WRITEBACK.
- IDLE: instr_ready=1 (only state where it is 1). instr_valid=1 latches instr -> DECODE. Otherwise stay.
- DECODE: opcode 0x0..0x3 map to alu_func 00/01/10/11. Register rs1/rs2 values (r0 forced 0) load into alu_src1/alu_src2 and the func into alu_func (registered, visible next cycle). Opcode >= 0x4: set an internal illegal flag; operands/func not updated. -> EXECUTE.
- EXECUTE: alu_* outputs stable. alu_result is sampled into the result register at the end of the cycle. -> WRITEBACK.
- WRITEBACK: legal op: wb_en=1, wb_addr=rd, wb_data=captured result, register file written at cycle end. rd=0: wb_en=0, write suppressed, done still pulses. Illegal op: wb_en=0, illegal=1, done=1. done=1 in all cases. -> IDLE.
- done, illegal and wb_en are registered pulses, high exactly the WRITEBACK cycle; wb_addr/wb_data hold their last value otherwise.
- Latency: accept at cycle T; DECODE T+1; EXECUTE T+2; WRITEBACK/done T+3; next accept earliest T+4. Throughput is 1 instruction per 4 cycles.
- Operand values are read in DECODE, so a back-to-back dependent instruction sees the prior writeback (no hazard possible).
- alu_func/alu_src* hold their values outside DECODE updates. The ALU is combinational; no ALU handshake.
- Width: the result is taken as delivered (MUL already truncated to low DATA_W bits by the ALU; SLT unsigned, 0x0001/0x0000).
- instr_valid while not in IDLE is ignored (not latched); the source must hold valid until ready.
- dbg_data reads are purely combinational, reflecting writes from the cycle after WRITEBACK.

Test Plan:
- Reset then dbg_data for all 16 addrs -> 0; instr_ready=1, alu_func=00, done=0.
- Preload via ADD r1=r0+r0, then a model-driven ALU (ADD/SUB/MUL/SLT): seed r1=5, r2=3 using a bench backdoor or ALU forcing. ADD r3,r1,r2 -> done at T+3, wb_addr=3, wb_data=0x0008. SUB r4,r2,r1 -> 0xFFFE.
- MUL r5 with r1=0x0100, r2=0x0100 -> wb_data=0x0000 (truncated). SLT r6,r2,r1 (3<5) -> 0x0001. SLT r7,r1,r2 -> 0x0000.
- Opcode 0x7 -> illegal=1 and done=1 at T+3, wb_en=0, no register changes; rd=0 legal op -> done=1, wb_en=0, r0 still 0.
- Hold instr_valid high continuously with 3 instructions -> accepts exactly at T, T+4, T+8; instr_ready low in between; dependent chain ADD r1,r1,r1 from r1=1 gives 2, 4, 8.
- Assert rst_n=0 during EXECUTE -> no done, no writeback, all regs 0, FSM IDLE immediately (asynchronous).
